conv_window_ctrl: RTL

Sequencer for the 3x3 convolution datapath (9 multipliers + adder tree). It accepts a raster-order pixel stream of one IMG_W x IMG_H feature map and tracks the sliding-window position. It flags each cycle in which the line-buffer window presented to the conv unit is complete, and delays that flag and the window coordinates by the datapath latency. The delayed outputs tag each conv result, and the block signals frame completion.

---
 rtl/conv_window_if.sv | 30 +++
 rtl/conv_window_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/conv_window_if.sv
// Handshake and tag bundle between the frame controller and the 3x3 conv window sequencer.
interface conv_window_if #(
  parameter int CW = 10
);
  logic          start;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic          win_valid;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          out_valid;
  logic [CW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_last;

  modport master (
    output start, abort, in_valid,
    input  in_ready, busy, done, win_valid, win_row, win_col,
           out_valid, out_row, out_col, out_last
  );

  modport slave (
    input  start, abort, in_valid,
    output in_ready, busy, done, win_valid, win_row, win_col,
           out_valid, out_row, out_col, out_last
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// Sliding 3x3 window sequencer: tracks raster position, flags complete windows and
// delays the window tag by the conv datapath latency so it lines up with each result.
module conv_window_ctrl #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int LAT   = 3,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  conv_window_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST_ROW   = CW'(IMG_H - 1);
  localparam logic [CW-1:0] LAST_COL   = CW'(IMG_W - 1);
  localparam logic [CW-1:0] NUM_RES_M1 = CW'((IMG_H - 2) * (IMG_W - 2) - 1);
  localparam logic [CW-1:0] TWO        = CW'(2);

  state_t        state_r;
  logic [CW-1:0] row_r;
  logic [CW-1:0] col_r;
  logic [CW-1:0] out_cnt_r;
  logic          in_ready_r;
  logic          busy_r;
  logic          done_r;
  logic          out_last_r;
  // Stage 0 is the window register itself, stage LAT is the result tag.
  logic [LAT:0]  dv_r;
  logic [CW-1:0] drow_r [0:LAT];
  logic [CW-1:0] dcol_r [0:LAT];

  logic          accept_s;
  logic          win_hit_s;
  logic          last_pix_s;
  logic [CW-1:0] cnt_now_s;
  logic          last_hit_s;

  assign accept_s   = bus.in_valid && in_ready_r;
  assign win_hit_s  = accept_s && (row_r >= TWO) && (col_r >= TWO);
  assign last_pix_s = (row_r == LAST_ROW) && (col_r == LAST_COL);
  // Count including the result leaving the tap this cycle, so the next one's index is known.
  assign cnt_now_s  = out_cnt_r + {{(CW-1){1'b0}}, dv_r[LAT]};
  assign last_hit_s = dv_r[LAT-1] && (cnt_now_s == NUM_RES_M1);

  // Frame FSM, raster counters and the window tag delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      row_r      <= '0;
      col_r      <= '0;
      out_cnt_r  <= '0;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      out_last_r <= 1'b0;
      dv_r       <= '0;
      for (int i = 0; i <= LAT; i++) begin
        drow_r[i] <= '0;
        dcol_r[i] <= '0;
      end
    end else if (bus.abort) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      out_last_r <= 1'b0;
      dv_r       <= '0;
      for (int i = 0; i <= LAT; i++) begin
        drow_r[i] <= '0;
        dcol_r[i] <= '0;
      end
    end else begin
      dv_r       <= {dv_r[LAT-1:0], win_hit_s};
      drow_r[0]  <= win_hit_s ? (row_r - TWO) : drow_r[0];
      dcol_r[0]  <= win_hit_s ? (col_r - TWO) : dcol_r[0];
      for (int i = 1; i <= LAT; i++) begin
        drow_r[i] <= drow_r[i-1];
        dcol_r[i] <= dcol_r[i-1];
      end
      out_last_r <= last_hit_s;
      out_cnt_r  <= cnt_now_s;

      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r    <= ST_RUN;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
            row_r      <= '0;
            col_r      <= '0;
            out_cnt_r  <= '0;
            out_last_r <= 1'b0;
            dv_r       <= '0;
            for (int i = 0; i <= LAT; i++) begin
              drow_r[i] <= '0;
              dcol_r[i] <= '0;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            if (col_r == LAST_COL) begin
              col_r <= '0;
              row_r <= row_r + CW'(1);
            end else begin
              col_r <= col_r + CW'(1);
            end
            if (last_pix_s) begin
              state_r    <= ST_DRAIN;
              in_ready_r <= 1'b0;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (out_last_r) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.win_valid = dv_r[0];
  assign bus.win_row   = drow_r[0];
  assign bus.win_col   = dcol_r[0];
  assign bus.out_valid = dv_r[LAT];
  assign bus.out_row   = drow_r[LAT];
  assign bus.out_col   = dcol_r[LAT];
  assign bus.out_last  = out_last_r;

endmodule
